// File: rtl/dot_prod_pkg.sv
// dot_prod_pkg: shared definitions for the dot_prod_engine slice.
//   - fixed-point format defaults (QN integer bits, QM fractional bits)
//   - flog2: constant floor(log2) helper, flog2(1) = 0
//   - state_t: engine FSM encoding (FETCH, DRAIN, DONE)
//   - fxp_fit: accumulator sum -> result word (arithmetic shift by QM,
//     optional clamp)
// Build option: DOT_PROD_SAT_EN
//   defined   -> results clamp to the signed BITWIDTH range
//   undefined -> results keep the low BITWIDTH bits (two's-complement wrap)
package dot_prod_pkg;

    localparam int QN_DEF       = 6;
    localparam int QM_DEF       = 11;
    localparam int BITWIDTH_DEF = QN_DEF + QM_DEF + 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int flog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((v >> (i + 1)) != 0) r = i + 1;
        end
        return r;
    endfunction

    // The sum arrives sign-extended to 64 bits so one function serves any
    // parameterisation. The caller keeps the low bw bits of the result.
    // The shift truncates toward -inf and does no rounding.
    function automatic logic signed [63:0] fxp_fit(input logic signed [63:0] sum,
                                                   input int qm, input int bw);
        logic signed [63:0] sh;
`ifdef DOT_PROD_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
`endif
        sh = sum >>> qm;
`ifdef DOT_PROD_SAT_EN
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw - 1));
        if (sh > hi)      sh = hi;
        else if (sh < lo) sh = lo;
`else
        if (bw < 1) sh = '0;
`endif
        return sh;
    endfunction

endpackage

// File: rtl/fxp_mac_row.sv
// fxp_mac_row: one output row of the column-serial matrix-vector product.
//   The weight x input product is registered in the cycle its operands are
//   presented. One cycle later it is added into partial-sum lane
//   (column mod DSP48_PER_ROW). The lanes are summed combinationally.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-low reset
//   i_en          operands valid this cycle
//   i_col         column index of the operands
//   i_w, i_x      signed weight and input element, Q(QN).(QM)
//   o_sum         sum of all lanes, 2*QM fractional bits
module fxp_mac_row import dot_prod_pkg::*; #(
    parameter  int BITWIDTH      = BITWIDTH_DEF,
    parameter  int ADDR_BITWIDTH = 2,
    parameter  int DSP48_PER_ROW = 4,
    localparam int PROD_W        = 2 * BITWIDTH,
    localparam int SUM_W         = PROD_W + ADDR_BITWIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_en,
    input  logic [ADDR_BITWIDTH-1:0]   i_col,
    input  logic signed [BITWIDTH-1:0] i_w,
    input  logic signed [BITWIDTH-1:0] i_x,
    output logic signed [SUM_W-1:0]    o_sum
);

    // DSP48_PER_ROW is a power of two, so mod reduces to a mask.
    localparam logic [ADDR_BITWIDTH-1:0] LANE_MASK = ADDR_BITWIDTH'(DSP48_PER_ROW - 1);

    logic signed [PROD_W-1:0]   r_prod;
    logic                       r_prod_vld;
    logic [ADDR_BITWIDTH-1:0]   r_prod_lane;
    logic signed [SUM_W-1:0]    r_lane [DSP48_PER_ROW];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_prod_lane <= '0;
            for (int l = 0; l < DSP48_PER_ROW; l++) r_lane[l] <= '0;
        end else begin
            r_prod_vld  <= i_en;
            r_prod_lane <= i_col & LANE_MASK;
            if (i_en) r_prod <= PROD_W'(i_w) * PROD_W'(i_x);
            for (int l = 0; l < DSP48_PER_ROW; l++) begin
                if (r_prod_vld && r_prod_lane == ADDR_BITWIDTH'(l))
                    r_lane[l] <= r_lane[l] + SUM_W'(r_prod);
            end
        end
    end

    always_comb begin
        o_sum = '0;
        for (int l = 0; l < DSP48_PER_ROW; l++) o_sum = o_sum + r_lane[l];
    end

endmodule

// File: rtl/dot_prod_engine.sv
// dot_prod_engine: column-serial fixed-point matrix-vector multiplier y = W*x.
//   The engine walks the columns 0..NCOL-1 and issues one column address per
//   cycle. The external RAM returns that weight column and x[c] one cycle
//   later. All NROW rows multiply-accumulate in parallel in fxp_mac_row.
//   After a two-cycle drain the fitted result is registered and dataReady is
//   held high until the next reset.
// Ports:
//   clock, reset     rising-edge clock, synchronous active-low reset
//   weightMemOutput  column W[*][c], row r at [r*BITWIDTH +: BITWIDTH]
//   inputVec         x[c], signed
//   dataReady        result valid (sticky until reset)
//   colAddressRead   column currently requested
//   outputVec        y, row r at [r*BITWIDTH +: BITWIDTH]
// Build option: DOT_PROD_SAT_EN selects saturating results; without it the
//   results wrap.
module dot_prod_engine import dot_prod_pkg::*; #(
    parameter  int NROW            = 16,
    parameter  int NCOL            = 4,
    parameter  int QN              = QN_DEF,
    parameter  int QM              = QM_DEF,
    parameter  int DSP48_PER_ROW   = 4,
    localparam int BITWIDTH        = QN + QM + 1,
    localparam int ADDR_BITWIDTH   = flog2(NCOL),
    localparam int MEMORY_BITWIDTH = BITWIDTH * NROW
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [MEMORY_BITWIDTH-1:0] weightMemOutput,
    input  logic [BITWIDTH-1:0]        inputVec,
    output logic                       dataReady,
    output logic [ADDR_BITWIDTH-1:0]   colAddressRead,
    output logic [MEMORY_BITWIDTH-1:0] outputVec
);

    localparam int SUM_W = 2 * BITWIDTH + ADDR_BITWIDTH;
    localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);

    state_t                            r_state;
    logic [ADDR_BITWIDTH-1:0]          r_col;
    logic                              r_drain;
    logic                              r_op_vld;
    logic [ADDR_BITWIDTH-1:0]          r_op_col;
    // The last-column token walks: operands, product, lane add, output load.
    logic [2:0]                        r_vld_pipe;
    logic                              r_ready;
    logic [NROW-1:0][BITWIDTH-1:0]     r_out;

    logic                              w_issue;
    logic                              w_last_issue;
    logic [NROW-1:0][SUM_W-1:0]        w_sum;
    logic [NROW-1:0][BITWIDTH-1:0]     w_fit;

    assign w_issue      = (r_state == FETCH);
    assign w_last_issue = w_issue && (r_col == LAST_COL);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= FETCH;
            r_col      <= '0;
            r_drain    <= 1'b0;
            r_op_vld   <= 1'b0;
            r_op_col   <= '0;
            r_vld_pipe <= '0;
            r_ready    <= 1'b0;
            r_out      <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (r_col == LAST_COL) begin
                        r_col   <= '0;
                        r_drain <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_col <= r_col + ADDR_BITWIDTH'(1);
                    end
                end
                DRAIN: begin
                    r_drain <= ~r_drain;
                    if (r_drain) r_state <= DONE;
                end
                DONE:    r_col <= '0;
                default: r_state <= FETCH;
            endcase

            // The RAM answers one cycle after the address, so the operand
            // qualifier and column tag are just the request delayed once.
            r_op_vld   <= w_issue;
            r_op_col   <= r_col;
            r_vld_pipe <= {r_vld_pipe[1:0], w_last_issue};

            if (r_vld_pipe[2]) begin
                r_out   <= w_fit;
                r_ready <= 1'b1;
            end
        end
    end

    for (genvar r = 0; r < NROW; r++) begin : g_row
        fxp_mac_row #(
            .BITWIDTH      (BITWIDTH),
            .ADDR_BITWIDTH (ADDR_BITWIDTH),
            .DSP48_PER_ROW (DSP48_PER_ROW)
        ) u_row (
            .clock (clock),
            .reset (reset),
            .i_en  (r_op_vld),
            .i_col (r_op_col),
            .i_w   (weightMemOutput[r*BITWIDTH +: BITWIDTH]),
            .i_x   (inputVec),
            .o_sum (w_sum[r])
        );
        assign w_fit[r] = BITWIDTH'(fxp_fit(64'($signed(w_sum[r])), QM, BITWIDTH));
    end

    assign dataReady      = r_ready;
    assign colAddressRead = r_col;
    assign outputVec      = r_out;

endmodule

// File: tb/tb_dot_prod_engine.sv
module tb_dot_prod_engine;

    localparam int NROW = 16;
    localparam int NCOL = 4;
    localparam int BW   = 18;
    localparam int AW   = 2;
    localparam int MW   = NROW * BW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [MW-1:0] weightMemOutput = '0;
    logic [BW-1:0] inputVec = '0;
    logic          dataReady;
    logic [AW-1:0] colAddressRead;
    logic [MW-1:0] outputVec;

    dot_prod_engine #(.NROW(NROW), .NCOL(NCOL), .QN(6), .QM(11), .DSP48_PER_ROW(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .weightMemOutput (weightMemOutput),
        .inputVec        (inputVec),
        .dataReady       (dataReady),
        .colAddressRead  (colAddressRead),
        .outputVec       (outputVec)
    );

    always #5 clock = ~clock;

    typedef struct {
        string     name;
        bit        ident;      // W[r][c] = 1.0 when r mod 4 == c, else 0
        logic [17:0] w;        // uniform weight when not ident
        logic [17:0] x   [4];
        logic [17:0] ex  [4];  // expected row value, indexed by r mod 4
    } vec_t;

    vec_t vt [7];
    logic [MW-1:0] sb_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] wcol(input int i, input int c);
        logic [MW-1:0] v;
        v = '0;
        for (int r = 0; r < NROW; r++)
            v[r*BW +: BW] = vt[i].ident ? (((r % 4) == c) ? 18'h00800 : 18'h0) : vt[i].w;
        return v;
    endfunction

    function automatic logic [MW-1:0] exp_vec(input int i);
        logic [MW-1:0] v;
        v = '0;
        for (int r = 0; r < NROW; r++) v[r*BW +: BW] = vt[i].ex[r % 4];
        return v;
    endfunction

    task automatic drive_random();
        for (int r = 0; r < NROW; r++) weightMemOutput[r*BW +: BW] = 18'($urandom);
        inputVec = 18'($urandom);
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b0;
        @(posedge clock); #1;
        chk({nm, "_rst_ready"}, MW'(dataReady), MW'(0));
        chk({nm, "_rst_out"},   outputVec,       '0);
        chk({nm, "_rst_addr"},  MW'(colAddressRead), MW'(0));
        reset = 1'b1;   // this cycle is cycle 0
    endtask

    // Runs one pass from cycle 0. The bench acts as the weight RAM: in
    // each cycle it returns the column the DUT addressed one cycle earlier.
    task automatic run_body(input int i);
        logic [AW-1:0] prev;
        logic [MW-1:0] held;
        bit seen;
        seen = 0;
        held = '0;
        prev = '0;
        sb_q.push_back(exp_vec(i));
        for (int t = 0; t <= 9; t++) begin
            if (t >= 1 && t <= NCOL) begin
                weightMemOutput = wcol(i, int'(prev));
                inputVec        = vt[i].x[prev];
            end else begin
                drive_random();
            end
            if (t < NCOL) chk($sformatf("%s_addr_c%0d", vt[i].name, t), MW'(colAddressRead), MW'(t));
            if (t >= 7)   chk($sformatf("%s_addr_done_c%0d", vt[i].name, t), MW'(colAddressRead), MW'(0));
            if (!seen) begin
                if (dataReady) begin
                    seen = 1;
                    chk({vt[i].name, "_ready_cycle"}, MW'(t), MW'(7));
                    if (sb_q.size() == 0) begin
                        chk({vt[i].name, "_sb_empty"}, MW'(1), MW'(0));
                    end else begin
                        held = sb_q.pop_front();
                        chk({vt[i].name, "_out"}, outputVec, held);
                    end
                end else if (t == 9) begin
                    chk({vt[i].name, "_ready_timeout"}, MW'(0), MW'(1));
                    if (sb_q.size() != 0) void'(sb_q.pop_front());
                end
            end else if (t == 9) begin
                chk({vt[i].name, "_hold_ready"}, MW'(dataReady), MW'(1));
                chk({vt[i].name, "_hold_out"},   outputVec, held);
            end
            prev = colAddressRead;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        vt[0] = '{"ones",  0, 18'h00800, '{18'h00800, 18'h00800, 18'h00800, 18'h00800},
                                        '{18'h02000, 18'h02000, 18'h02000, 18'h02000}};
        vt[1] = '{"neg",   0, 18'h3F800, '{18'h00400, 18'h00400, 18'h00400, 18'h00400},
                                        '{18'h3F000, 18'h3F000, 18'h3F000, 18'h3F000}};
        vt[2] = '{"ident", 1, 18'h00000, '{18'h00800, 18'h01000, 18'h01800, 18'h02000},
                                        '{18'h00800, 18'h01000, 18'h01800, 18'h02000}};
        vt[3] = '{"trunc_pos", 0, 18'h00001, '{18'h00400, 18'h00400, 18'h00400, 18'h00400},
                                            '{18'h00002, 18'h00002, 18'h00002, 18'h00002}};
        vt[4] = '{"trunc_neg", 0, 18'h3FFFF, '{18'h00400, 18'h00400, 18'h00400, 18'h00400},
                                            '{18'h3FFFE, 18'h3FFFE, 18'h3FFFE, 18'h3FFFE}};
`ifdef DOT_PROD_SAT_EN
        vt[5] = '{"ovf_pos", 0, 18'h0F800, '{18'h0F800, 18'h0F800, 18'h0F800, 18'h0F800},
                                          '{18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF}};
        vt[6] = '{"ovf_neg", 0, 18'h30800, '{18'h0F800, 18'h0F800, 18'h0F800, 18'h0F800},
                                          '{18'h20000, 18'h20000, 18'h20000, 18'h20000}};
`else
        // 3844 * 2^11 = 0x782000 -> low 18 bits 0x02000; its negation wraps to 0x3E000
        vt[5] = '{"ovf_pos", 0, 18'h0F800, '{18'h0F800, 18'h0F800, 18'h0F800, 18'h0F800},
                                          '{18'h02000, 18'h02000, 18'h02000, 18'h02000}};
        vt[6] = '{"ovf_neg", 0, 18'h30800, '{18'h0F800, 18'h0F800, 18'h0F800, 18'h0F800},
                                          '{18'h3E000, 18'h3E000, 18'h3E000, 18'h3E000}};
`endif

        @(posedge clock); #1;
        for (int i = 0; i < 7; i++) begin
            do_reset(vt[i].name);
            run_body(i);
        end

        // Abort a pass in cycle 2, then rerun all-1.0 with full latency.
        do_reset("abort_pre");
        weightMemOutput = wcol(2, 0);
        inputVec        = 18'h01800;
        @(posedge clock); #1;           // cycle 1
        weightMemOutput = wcol(2, 0);
        @(posedge clock); #1;           // cycle 2
        chk("abort_addr_c2", MW'(colAddressRead), MW'(2));
        do_reset("abort");
        run_body(0);

        chk("sb_drained", MW'(sb_q.size()), MW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
